piggy_report_scheduler: RTL and testbench

- Sequences the UART byte transmitter for the piggy-bank datapath.
- Collects change pulses from the four coin counters and a manual report request, and coalesces them into a single pending flag.
- Snapshots the four 3-digit ASCII amounts and streams a fixed 25-byte frame, one byte per transmitter handshake.
- Sits between the counter/numtoascii stage and the byte-level UART TX, replacing direct start_sending wiring.

---
 rtl/piggy_pkg.sv | 46 ++++
 rtl/piggy_report_scheduler_if.sv | 11 +
 rtl/piggy_frame_rom.sv | 40 ++++
 rtl/piggy_report_scheduler.sv | 144 ++++++++++++++
 tb/tb_piggy_report_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piggy_pkg.sv
// Shared types and constants for the piggy-bank report scheduler:
// FSM states, frame geometry, frame byte constants and the snapshot record.
package piggy_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam int         FRAME_LEN = 25;
  localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

  localparam logic [7:0] LBL_TEN  = 8'h54;
  localparam logic [7:0] LBL_FIVE = 8'h46;
  localparam logic [7:0] LBL_TWO  = 8'h57;
  localparam logic [7:0] LBL_ONE  = 8'h4F;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef struct packed {
    logic [23:0] ten;
    logic [23:0] five;
    logic [23:0] two;
    logic [23:0] one;
  } snap_t;

  localparam snap_t SNAP_RESET = {12{8'h20}};

  // pos 0 is the hundreds digit
  function automatic logic [7:0] digit(input logic [23:0] value, input logic [1:0] pos);
    logic [7:0] d;
    case (pos)
      2'd0:    d = value[23:16];
      2'd1:    d = value[15:8];
      2'd2:    d = value[7:0];
      default: d = CH_SPACE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/piggy_report_scheduler_if.sv
// Byte-level handshake between the report scheduler (master) and the UART
// byte transmitter (slave).
interface piggy_report_scheduler_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;

  modport master (output tx_dv, output tx_byte, input tx_active, input tx_done);
  modport slave  (input tx_dv, input tx_byte, output tx_active, output tx_done);
endinterface

// File: rtl/piggy_frame_rom.sv
// Combinational frame byte selector: maps a frame index and the latched
// snapshot to the byte of "T:ddd F:ddd W:ddd O:ddd\r\n".
module piggy_frame_rom
  import piggy_pkg::*;
(
  input  logic [4:0] idx,
  input  snap_t      snap,
  output logic [7:0] data
);

  // frame layout lookup
  always_comb begin
    data = CH_SPACE;
    case (idx)
      5'd0:                 data = LBL_TEN;
      5'd6:                 data = LBL_FIVE;
      5'd12:                data = LBL_TWO;
      5'd18:                data = LBL_ONE;
      5'd1, 5'd7,
      5'd13, 5'd19:         data = CH_COLON;
      5'd5, 5'd11, 5'd17:   data = CH_SPACE;
      5'd2:                 data = digit(snap.ten, 2'd0);
      5'd3:                 data = digit(snap.ten, 2'd1);
      5'd4:                 data = digit(snap.ten, 2'd2);
      5'd8:                 data = digit(snap.five, 2'd0);
      5'd9:                 data = digit(snap.five, 2'd1);
      5'd10:                data = digit(snap.five, 2'd2);
      5'd14:                data = digit(snap.two, 2'd0);
      5'd15:                data = digit(snap.two, 2'd1);
      5'd16:                data = digit(snap.two, 2'd2);
      5'd20:                data = digit(snap.one, 2'd0);
      5'd21:                data = digit(snap.one, 2'd1);
      5'd22:                data = digit(snap.one, 2'd2);
      5'd23:                data = CH_CR;
      5'd24:                data = CH_LF;
      default:              data = 8'h00;
    endcase
  end

endmodule

// File: rtl/piggy_report_scheduler.sv
// Report scheduler: coalesces change/report requests into one pending flag and
// streams a 25-byte snapshot frame to the UART byte transmitter, one byte per tx_done.
module piggy_report_scheduler
  import piggy_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               change_i,
  input  logic                     report_req,
  input  logic [23:0]              ascii_ten,
  input  logic [23:0]              ascii_five,
  input  logic [23:0]              ascii_two,
  input  logic [23:0]              ascii_one,
  piggy_report_scheduler_if.master tx,
  output logic                     busy,
  output logic                     pending,
  output logic                     frame_done,
  output logic                     tx_err,
  output logic [7:0]               frame_count
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD     = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t        state;
  logic [4:0]    idx;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  snap_t         snap;
  logic [4:0]    rom_idx;
  logic [7:0]    rom_byte;
  logic          req;

  assign req = (|change_i) | report_req;

  // The byte for the upcoming SEND is registered on the transition into SEND,
  // so the ROM looks one index ahead while waiting.
  assign rom_idx = (state == WAIT) ? (idx + 5'd1) : 5'd0;

  piggy_frame_rom u_rom (
    .idx  (rom_idx),
    .snap (snap),
    .data (rom_byte)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 5'd0;
      timer       <= '0;
      gap_cnt     <= '0;
      snap        <= SNAP_RESET;
      tx.tx_dv    <= 1'b0;
      tx.tx_byte  <= 8'h00;
      busy        <= 1'b0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      tx_err      <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      tx.tx_dv   <= 1'b0;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
      if (req) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending && !tx.tx_active) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          snap       <= '{ten: ascii_ten, five: ascii_five, two: ascii_two, one: ascii_one};
          idx        <= 5'd0;
          state      <= SEND;
          tx.tx_dv   <= 1'b1;
          tx.tx_byte <= rom_byte;
          // a request landing in this very cycle keeps the flag set
          if (!req) begin
            pending <= 1'b0;
          end
        end
        SEND: begin
          timer <= TIMEOUT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (tx.tx_done) begin
            if (idx == LAST_IDX) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              idx        <= idx + 5'd1;
              state      <= SEND;
              tx.tx_dv   <= 1'b1;
              tx.tx_byte <= rom_byte;
            end
          end else if (timer <= TW'(1)) begin
            // abort after TIMEOUT_CYCLES waiting cycles and re-arm a full retry
            tx_err  <= 1'b1;
            pending <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piggy_report_scheduler.sv
// Self-checking bench for piggy_report_scheduler: table-driven frames, directed
// multi-cycle corner cases and randomized frames against a string-level frame model.
module tb_piggy_report_scheduler;

  localparam int GAP = 16;
  localparam int TMO = 50;

  logic        clk;
  logic        rst;
  logic [3:0]  change_i;
  logic        report_req;
  logic [23:0] ascii_ten, ascii_five, ascii_two, ascii_one;
  logic        busy, pending, frame_done, tx_err;
  logic [7:0]  frame_count;

  piggy_report_scheduler_if bus();

  piggy_report_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .change_i    (change_i),
    .report_req  (report_req),
    .ascii_ten   (ascii_ten),
    .ascii_five  (ascii_five),
    .ascii_two   (ascii_two),
    .ascii_one   (ascii_one),
    .tx          (bus.master),
    .busy        (busy),
    .pending     (pending),
    .frame_done  (frame_done),
    .tx_err      (tx_err),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_delay = 10;
  int suppress_at = -1;
  int done_timer = 0;
  int exp_fc = 0;

  logic [7:0] rx_q[$];
  int dv_cyc[$];
  int fd_cyc[$];
  int err_cyc[$];

  typedef struct {
    int    ten;
    int    five;
    int    two;
    int    one;
    int    delay;
    string frame;
  } vec_t;

  vec_t vecs[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmitter model and event logger: answers each tx_dv with a tx_done
  // done_delay cycles later, except for the byte selected by suppress_at.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.tx_done = 1'b0;
      if (rst) begin
        done_timer = 0;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) bus.tx_done = 1'b1;
      end
      if (bus.tx_dv) begin
        rx_q.push_back(bus.tx_byte);
        dv_cyc.push_back(cyc);
        if (rx_q.size() - 1 != suppress_at) done_timer = done_delay;
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (tx_err) err_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  function automatic logic [23:0] to_ascii(input int v);
    return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
  endfunction

  // Reference frame text without the trailing CR LF
  function automatic string model_frame(input int t, input int f, input int w, input int o);
    return $sformatf("T:%03d F:%03d W:%03d O:%03d", t, f, w, o);
  endfunction

  task automatic clear_logs();
    rx_q.delete();
    dv_cyc.delete();
    fd_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic wait_until_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " byte wait"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fd(input int n, input int budget, input string name);
    int k = 0;
    while (fd_cyc.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " frame_done wait"}, 32'(fd_cyc.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input int base, input string exp, input string name);
    int bad_at = -1;
    logic [7:0] want = 8'h00;
    logic [7:0] got = 8'h00;
    checks++;
    if (rx_q.size() < base + 25) begin
      errors++;
      $display("FAIL %s: received %0d bytes, expected 25", name, rx_q.size() - base);
    end else begin
      for (int i = 0; i < 25; i++) begin
        logic [7:0] e;
        e = (i < 23) ? exp[i] : ((i == 23) ? 8'h0D : 8'h0A);
        if (bad_at < 0 && rx_q[base + i] !== e) begin
          bad_at = i;
          want = e;
          got = rx_q[base + i];
        end
      end
      if (bad_at >= 0) begin
        errors++;
        $display("FAIL %s: byte %0d got 0x%02h, expected 0x%02h", name, bad_at, got, want);
      end
    end
  endtask

  task automatic check_pacing(input int base, input int d, input string name);
    int bad = 0;
    if (dv_cyc.size() < base + 25) bad = 99;
    else for (int i = 1; i < 25; i++) if (dv_cyc[base + i] - dv_cyc[base + i - 1] != d + 1) bad++;
    check({name, " pacing"}, 32'(bad), 32'd0);
  endtask

  // One request-triggered frame from idle, with latency, content and gap checks
  task automatic run_single(input int t, input int f, input int w, input int o, input int d,
                            input logic [3:0] chg, input logic rq, input string exp, input string name);
    int fdc;
    ascii_ten = to_ascii(t);
    ascii_five = to_ascii(f);
    ascii_two = to_ascii(w);
    ascii_one = to_ascii(o);
    done_delay = d;
    clear_logs();
    change_i = chg;
    report_req = rq;
    tick(1);
    change_i = 4'd0;
    report_req = 1'b0;
    check({name, " pending N+1"}, 32'(pending), 32'd1);
    check({name, " busy N+1"}, 32'(busy), 32'd0);
    tick(1);
    check({name, " busy N+2"}, 32'(busy), 32'd1);
    check({name, " dv N+2"}, 32'(bus.tx_dv), 32'd0);
    tick(1);
    check({name, " dv N+3"}, 32'(bus.tx_dv), 32'd1);
    check({name, " pending cleared"}, 32'(pending), 32'd0);
    wait_fd(1, 25 * (d + 1) + 40, name);
    exp_fc = (exp_fc + 1) % 256;
    check_frame(0, exp, name);
    check_pacing(0, d, name);
    fdc = (fd_cyc.size() > 0) ? fd_cyc[0] : cyc;
    check({name, " frame_done timing"}, 32'(fdc), 32'((dv_cyc.size() >= 25) ? dv_cyc[24] + d + 1 : -1));
    check({name, " frame_count"}, 32'(frame_count), 32'(exp_fc));
    wait_until_cyc(fdc + GAP - 1);
    check({name, " busy in gap"}, 32'(busy), 32'd1);
    tick(1);
    check({name, " idle after gap"}, 32'(busy), 32'd0);
    check({name, " frame count"}, 32'(fd_cyc.size()), 32'd1);
  endtask

  initial begin
    int n0, e0, r0, nb;
    int t, f, w, o, d;
    logic [3:0] chg;
    string s107, s108;

    vecs[0] = '{ten: 12,  five: 3, two: 0,  one: 107, delay: 10, frame: "T:012 F:003 W:000 O:107"};
    vecs[1] = '{ten: 999, five: 0, two: 55, one: 1,   delay: 1,  frame: "T:999 F:000 W:055 O:001"};
    vecs[2] = '{ten: 0,   five: 0, two: 0,  one: 0,   delay: 3,  frame: "T:000 F:000 W:000 O:000"};
    s107 = "T:012 F:003 W:000 O:107";
    s108 = "T:012 F:003 W:000 O:108";

    rst = 1'b1;
    change_i = 4'd0;
    report_req = 1'b0;
    ascii_ten = 24'h202020;
    ascii_five = 24'h202020;
    ascii_two = 24'h202020;
    ascii_one = 24'h202020;
    bus.tx_active = 1'b0;
    tick(3);
    check("reset tx_dv", 32'(bus.tx_dv), 32'd0);
    check("reset tx_byte", 32'(bus.tx_byte), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pending", 32'(pending), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset tx_err", 32'(tx_err), 32'd0);
    check("reset frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 3; i++)
      run_single(vecs[i].ten, vecs[i].five, vecs[i].two, vecs[i].one, vecs[i].delay,
                 4'd0, 1'b1, vecs[i].frame, $sformatf("vec%0d", i));

    // Coalescing plus snapshot isolation across a mid-frame input change
    ascii_ten = to_ascii(12);
    ascii_five = to_ascii(3);
    ascii_two = to_ascii(0);
    ascii_one = to_ascii(107);
    done_delay = 10;
    clear_logs();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    wait_bytes(6, 200, "coalesce b5");
    change_i = 4'b0001;
    ascii_one = to_ascii(108);
    tick(1);
    change_i = 4'd0;
    check("coalesce pending", 32'(pending), 32'd1);
    wait_bytes(11, 200, "coalesce b10");
    change_i = 4'b0100;
    tick(1);
    change_i = 4'd0;
    wait_fd(2, 1000, "coalesce");
    exp_fc = (exp_fc + 2) % 256;
    check_frame(0, s107, "coalesce frame1");
    check_frame(25, s108, "coalesce frame2");
    check("coalesce gap", 32'((dv_cyc.size() > 25) ? dv_cyc[25] : -1),
          32'((fd_cyc.size() > 0) ? fd_cyc[0] + GAP + 2 : -2));
    wait_until_cyc(((fd_cyc.size() > 1) ? fd_cyc[1] : cyc) + 80);
    check("coalesce frames", 32'(fd_cyc.size()), 32'd2);
    check("coalesce bytes", 32'(rx_q.size()), 32'd50);
    check("coalesce frame_count", 32'(frame_count), 32'(exp_fc));

    // Request in the SNAP cycle keeps pending set
    done_delay = 2;
    clear_logs();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    tick(1);
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    check("snap collision pending", 32'(pending), 32'd1);
    wait_fd(2, 400, "snap collision");
    exp_fc = (exp_fc + 2) % 256;
    wait_until_cyc(((fd_cyc.size() > 1) ? fd_cyc[1] : cyc) + 60);
    check("snap collision frames", 32'(fd_cyc.size()), 32'd2);
    check("snap collision frame_count", 32'(frame_count), 32'(exp_fc));

    // Timeout on byte 7, then full retry after the gap
    done_delay = 3;
    suppress_at = 7;
    clear_logs();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    r0 = 0;
    while (err_cyc.size() == 0 && r0 < 200) begin
      tick(1);
      r0++;
    end
    check("timeout seen", 32'(err_cyc.size()), 32'd1);
    e0 = (err_cyc.size() > 0) ? err_cyc[0] : cyc;
    check("timeout timing", 32'(e0), 32'((dv_cyc.size() > 7) ? dv_cyc[7] + TMO + 1 : -1));
    check("timeout frame_count", 32'(frame_count), 32'(exp_fc));
    check("timeout pending", 32'(pending), 32'd1);
    check("timeout no frame_done", 32'(fd_cyc.size()), 32'd0);
    suppress_at = -1;
    wait_fd(1, 400, "retry");
    exp_fc = (exp_fc + 1) % 256;
    check("retry restart", 32'((dv_cyc.size() > 8) ? dv_cyc[8] : -1), 32'(e0 + GAP + 2));
    check_frame(8, s108, "retry frame");
    wait_until_cyc(((fd_cyc.size() > 0) ? fd_cyc[0] : cyc) + GAP + 2);
    check("retry bytes", 32'(rx_q.size()), 32'd33);
    check("retry frame_count", 32'(frame_count), 32'(exp_fc));

    // Busy transmitter holds off the frame
    done_delay = 2;
    bus.tx_active = 1'b1;
    clear_logs();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    tick(20);
    check("txbusy no dv", 32'(rx_q.size()), 32'd0);
    check("txbusy idle", 32'(busy), 32'd0);
    check("txbusy pending", 32'(pending), 32'd1);
    bus.tx_active = 1'b0;
    tick(1);
    check("txbusy snap", 32'(busy), 32'd1);
    check("txbusy dv early", 32'(bus.tx_dv), 32'd0);
    tick(1);
    check("txbusy dv", 32'(bus.tx_dv), 32'd1);
    wait_fd(1, 200, "txbusy");
    exp_fc = (exp_fc + 1) % 256;
    check_frame(0, s108, "txbusy frame");
    wait_until_cyc(((fd_cyc.size() > 0) ? fd_cyc[0] : cyc) + GAP + 2);

    // Randomized frames against the text model
    for (int r = 0; r < 6; r++) begin
      t = $urandom_range(0, 999);
      f = $urandom_range(0, 999);
      w = $urandom_range(0, 999);
      o = $urandom_range(0, 999);
      d = $urandom_range(1, 6);
      chg = (r == 5) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
      run_single(t, f, w, o, d, chg, (r == 5) ? 1'b1 : 1'b0, model_frame(t, f, w, o),
                 $sformatf("rand%0d", r));
    end

    // Asynchronous reset while waiting on byte 12
    done_delay = 10;
    clear_logs();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    wait_bytes(13, 400, "midreset");
    rst = 1'b1;
    #1;
    check("midreset tx_dv", 32'(bus.tx_dv), 32'd0);
    check("midreset tx_byte", 32'(bus.tx_byte), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset pending", 32'(pending), 32'd0);
    check("midreset frame_done", 32'(frame_done), 32'd0);
    check("midreset tx_err", 32'(tx_err), 32'd0);
    check("midreset frame_count", 32'(frame_count), 32'd0);
    exp_fc = 0;
    tick(3);
    rst = 1'b0;
    nb = rx_q.size();
    tick(80);
    check("midreset no dv", 32'(rx_q.size()), 32'(nb));
    check("midreset busy after", 32'(busy), 32'd0);

    // frame_count wraps after 256 frames
    done_delay = 1;
    for (int k = 0; k < 256; k++) begin
      clear_logs();
      report_req = 1'b1;
      n0 = cyc;
      tick(1);
      report_req = 1'b0;
      wait_fd(1, 120, "wrap");
      exp_fc = (exp_fc + 1) % 256;
      wait_until_cyc(((fd_cyc.size() > 0) ? fd_cyc[0] : n0) + GAP + 1);
      check("wrap frame_count", 32'(frame_count), 32'(exp_fc));
    end
    check("wrap final zero", 32'(frame_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
